// File: rtl/wb_spi_slave.sv
// wb_spi_slave: Wishbone SPI mode-0 slave with RX/TX byte FIFOs; define WB_SPI_SLAVE_IRQ_EN to build the interrupt logic
module wb_spi_slave #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] DUMMY_BYTE = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        spi_sck_i,
  input  logic        spi_cs_ni,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q;
  logic sck_rise, cs_fall, cs_rise, cs_sync, mosi;
  state_t state, state_n;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift, rx_byte_in, rx_head;
  logic tx_load, rx_push, shift_en;
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wp, rx_rp, tx_wp, tx_rp, rx_cnt, tx_cnt;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic req, wr, rd, data_wr, data_rd, ctrl_wr, rx_flush, tx_flush;
  logic tx_push, tx_pop, rx_wr, rx_pop, rx_overrun, tx_underrun;
  logic [31:0] status, rd_data;
  logic [3:0] irq_en, irq_stat;
  logic unused;
  assign unused = ^{wb_adr_i[1:0], wb_dat_i[31:10]};
  // CS flops reset to deselected so no spurious edge or MISO drive follows reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sck_q <= 3'b000;
      cs_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q <= {sck_q[1:0], spi_sck_i};
      cs_q <= {cs_q[1:0], spi_cs_ni};
      mosi_q <= {mosi_q[0], spi_mosi_i};
    end
  assign cs_sync = cs_q[1];
  assign mosi = mosi_q[1];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_fall = ~cs_q[1] & cs_q[2];
  assign cs_rise = cs_q[1] & ~cs_q[2];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    tx_load = 1'b0;
    rx_push = 1'b0;
    if (cs_rise) state_n = IDLE;
    else begin
      case (state)
        IDLE:    state_n = cs_fall ? LOAD : IDLE;
        LOAD:    begin
          tx_load = 1'b1;
          state_n = SHIFT;
        end
        SHIFT:   begin
          rx_push = sck_rise && bit_cnt == 3'd7;
          tx_load = sck_rise && bit_cnt == 3'd7;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  assign shift_en = (state == SHIFT) & sck_rise & ~cs_rise;
  assign rx_byte_in = {rx_shift, mosi};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bit_cnt <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
    end else begin
      bit_cnt <= (state == LOAD) ? 3'd0 : shift_en ? bit_cnt + 3'd1 : bit_cnt;
      rx_shift <= shift_en ? rx_byte_in[6:0] : rx_shift;
      tx_shift <= tx_load ? (tx_empty ? DUMMY_BYTE : tx_mem[tx_rp[AW-1:0]]) :
                  shift_en ? {tx_shift[6:0], 1'b0} : tx_shift;
    end
  assign spi_miso_o = ~cs_sync & tx_shift[7];
  assign spi_miso_oe_o = ~cs_sync;
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr = req & wb_we_i;
  assign rd = req & ~wb_we_i;
  assign data_wr = wr & (wb_adr_i[3:2] == 2'd0);
  assign data_rd = rd & (wb_adr_i[3:2] == 2'd0);
  assign ctrl_wr = wr & (wb_adr_i[3:2] == 2'd2);
  assign rx_flush = ctrl_wr & wb_dat_i[8];
  assign tx_flush = ctrl_wr & wb_dat_i[9];
  assign rx_cnt = rx_wp - rx_rp;
  assign tx_cnt = tx_wp - tx_rp;
  assign rx_empty = rx_cnt == '0;
  assign tx_empty = tx_cnt == '0;
  assign rx_full = rx_cnt == (AW+1)'(FIFO_DEPTH);
  assign tx_full = tx_cnt == (AW+1)'(FIFO_DEPTH);
  assign tx_push = data_wr & ~tx_full;
  assign rx_pop = data_rd & ~rx_empty;
  assign tx_pop = tx_load & ~tx_empty;
  assign tx_underrun = tx_load & tx_empty;
  assign rx_wr = rx_push & ~rx_full;
  assign rx_overrun = rx_push & rx_full;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rx_wp <= '0;
      rx_rp <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      rx_wp <= rx_flush ? '0 : rx_wp + (AW+1)'(rx_wr);
      rx_rp <= rx_flush ? '0 : rx_rp + (AW+1)'(rx_pop);
      tx_wp <= tx_flush ? '0 : tx_wp + (AW+1)'(tx_push);
      tx_rp <= tx_flush ? '0 : tx_rp + (AW+1)'(tx_pop);
    end
  always_ff @(posedge clk_i) begin
    if (rx_wr) rx_mem[rx_wp[AW-1:0]] <= rx_byte_in;
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wb_dat_i[7:0];
  end
  assign rx_head = rx_empty ? 8'd0 : rx_mem[rx_rp[AW-1:0]];
  assign status = {8'd0, 8'(tx_cnt), 8'(rx_cnt), 3'd0, ~cs_sync, tx_full, tx_empty, rx_full, rx_empty};
  assign rd_data = (wb_adr_i[3:2] == 2'd0) ? {24'd0, rx_head} :
                   (wb_adr_i[3:2] == 2'd1) ? status :
                   (wb_adr_i[3:2] == 2'd2) ? {28'd0, irq_en} : {28'd0, irq_stat};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd ? rd_data : '0;
    end
`ifdef WB_SPI_SLAVE_IRQ_EN
  logic irq_wr;
  logic [3:0] irq_set;
  assign irq_wr = wr & (wb_adr_i[3:2] == 2'd3);
  assign irq_set = {cs_rise, tx_underrun, rx_overrun, rx_push};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      irq_en <= 4'd0;
      irq_stat <= 4'd0;
      irq_o <= 1'b0;
    end else begin
      irq_en <= ctrl_wr ? wb_dat_i[3:0] : irq_en;
      irq_stat <= (irq_stat & ~(irq_wr ? wb_dat_i[3:0] : 4'd0)) | irq_set;
      irq_o <= |(irq_stat & irq_en);
    end
`else
  assign irq_en = 4'd0;
  assign irq_stat = 4'd0;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_spi_slave.sv
// tb_wb_spi_slave: directed Wishbone/SPI vectors for wb_spi_slave with hand-computed expectations
`timescale 1ns/1ps
module tb_wb_spi_slave;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0] wb_adr_i = 4'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic wb_ack_o;
  logic spi_sck_i = 1'b0, spi_cs_ni = 1'b1, spi_mosi_i = 1'b0;
  logic spi_miso_o, spi_miso_oe_o, irq_o;
  int vectors = 0;
  int errors = 0;
`ifdef WB_SPI_SLAVE_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  always #5 clk_i = ~clk_i;
  wb_spi_slave dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .spi_sck_i(spi_sck_i), .spi_cs_ni(spi_cs_ni), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o), .irq_o(irq_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wb_go(input logic we, input logic [3:0] adr, input logic [31:0] d, output logic [31:0] q);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i = we;
    wb_adr_i = adr;
    wb_dat_i = d;
    @(negedge clk_i);
    chk("ack", 32'(wb_ack_o), 32'd1);
    q = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i = 1'b0;
  endtask
  task automatic wb_wr(input logic [3:0] adr, input logic [31:0] d);
    logic [31:0] q;
    @(negedge clk_i);
    wb_go(1'b1, adr, d, q);
  endtask
  task automatic wb_rd(input logic [3:0] adr, output logic [31:0] q);
    @(negedge clk_i);
    wb_go(1'b0, adr, 32'd0, q);
  endtask
  task automatic spi_bit(input logic b, input logic inj, input logic iwe, input logic [3:0] iadr,
                         input logic [31:0] idat, output logic m, output logic [31:0] q);
    spi_mosi_i = b;
    repeat (4) @(negedge clk_i);
    m = spi_miso_o;
    spi_sck_i = 1'b1;
    q = 32'd0;
    if (inj) begin
      repeat (2) @(negedge clk_i);
      wb_go(iwe, iadr, idat, q);
      @(negedge clk_i);
    end else repeat (4) @(negedge clk_i);
    spi_sck_i = 1'b0;
  endtask
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input logic inj, input logic iwe,
                          input logic [3:0] iadr, input logic [31:0] idat,
                          output logic [7:0] rxb, output logic [31:0] q);
    logic m;
    logic [31:0] qq;
    rxb = 8'd0;
    q = 32'd0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_bit(tx[i], inj && i == 0, iwe, iadr, idat, m, qq);
      rxb[i] = m;
      if (inj && i == 0) q = qq;
    end
  endtask
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
    logic [31:0] q;
    spi_xfer(tx, 8, 1'b0, 1'b0, 4'd0, 32'd0, rxb, q);
  endtask
  task automatic cs_low();
    @(negedge clk_i);
    spi_cs_ni = 1'b0;
    repeat (5) @(negedge clk_i);
  endtask
  task automatic cs_high();
    repeat (4) @(negedge clk_i);
    spi_cs_ni = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask
  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [31:0] q;
    logic [7:0] mb;
    repeat (3) @(negedge clk_i);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_pins", {28'd0, wb_ack_o, spi_miso_o, spi_miso_oe_o, irq_o}, 32'd0);
    rst_i = 1'b0;
    wb_rd(4'h4, q);
    chk("rst_status", q, 32'h0000_0005);
    wb_rd(4'hC, q);
    chk("rst_irqstat", q, 32'd0);
    wb_wr(4'h0, 32'hA5);
    wb_wr(4'h0, 32'h3C);
    wb_rd(4'h4, q);
    chk("st_tx2", q, 32'h0002_0001);
    wb_wr(4'h8, 32'h4);
    wb_rd(4'h8, q);
    chk("ctrl_rd", q, IRQ ? 32'h4 : 32'h0);
    @(negedge clk_i);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = 4'h4;
    @(negedge clk_i);
    chk("ack_first", 32'(wb_ack_o), 32'd1);
    @(negedge clk_i);
    chk("ack_gap", 32'(wb_ack_o), 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    cs_low();
    chk("oe_sel", 32'(spi_miso_oe_o), 32'd1);
    wb_rd(4'h4, q);
    chk("st_busy", q, 32'h0001_0011);
    spi_byte(8'h12, mb);
    chk("miso_a5", 32'(mb), 32'hA5);
    spi_byte(8'h34, mb);
    chk("miso_3c", 32'(mb), 32'h3C);
    cs_high();
    wb_rd(4'h4, q);
    chk("st_rx2", q, 32'h0000_0204);
    wb_rd(4'h0, q);
    chk("rx_12", q, 32'h12);
    wb_rd(4'h0, q);
    chk("rx_34", q, 32'h34);
    wb_rd(4'h0, q);
    chk("rx_empty_rd", q, 32'h0);
    wb_rd(4'hC, q);
    chk("irq_basic", q, IRQ ? 32'hD : 32'h0);
    chk("irq_o_basic", 32'(irq_o), 32'(IRQ));
    wb_wr(4'hC, 32'hF);
    wb_rd(4'hC, q);
    chk("w1c_all", q, 32'h0);
    chk("irq_o_clr", 32'(irq_o), 32'd0);
    cs_low();
    spi_byte(8'h55, mb);
    chk("miso_dummy", 32'(mb), 32'hFF);
    wb_rd(4'hC, q);
    chk("irq_under", q, IRQ ? 32'h5 : 32'h0);
    chk("irq_o_under", 32'(irq_o), 32'(IRQ));
    cs_high();
    wb_rd(4'h0, q);
    chk("rx_55", q, 32'h55);
    wb_wr(4'hC, 32'hF);
    cs_low();
    for (int i = 0; i < 17; i++) spi_byte(8'(32'h80 + i), mb);
    cs_high();
    wb_rd(4'h4, q);
    chk("st_ovr", q, 32'h0000_1006);
    wb_rd(4'hC, q);
    chk("irq_ovr", q, IRQ ? 32'hF : 32'h0);
    for (int i = 0; i < 16; i++) begin
      wb_rd(4'h0, q);
      chk("ovr_data", q, 32'h80 + i);
    end
    wb_rd(4'h4, q);
    chk("st_ovr_drained", q, 32'h0000_0005);
    wb_wr(4'hC, 32'hF);
    wb_wr(4'h0, 32'hC3);
    wb_wr(4'h0, 32'h96);
    cs_low();
    spi_xfer(8'hF0, 5, 1'b0, 1'b0, 4'd0, 32'd0, mb, q);
    chk("abort_miso", 32'(mb), 32'hC0);
    cs_high();
    wb_rd(4'h4, q);
    chk("st_abort", q, 32'h0001_0001);
    wb_rd(4'hC, q);
    chk("irq_abort", q, IRQ ? 32'h8 : 32'h0);
    cs_low();
    spi_byte(8'h5A, mb);
    chk("miso_fresh", 32'(mb), 32'h96);
    cs_high();
    wb_rd(4'h0, q);
    chk("rx_5a", q, 32'h5A);
    wb_wr(4'hC, 32'hF);
    for (int i = 0; i < 17; i++) wb_wr(4'h0, i);
    wb_rd(4'h4, q);
    chk("st_txfull", q, 32'h0010_0009);
    wb_wr(4'h8, 32'h204);
    wb_rd(4'h4, q);
    chk("st_txflush", q, 32'h0000_0005);
    cs_low();
    spi_byte(8'h01, mb);
    spi_byte(8'h02, mb);
    spi_byte(8'h03, mb);
    wb_rd(4'h4, q);
    chk("st_rx3", q, 32'h0000_0314);
    spi_xfer(8'h04, 8, 1'b1, 1'b0, 4'h0, 32'd0, mb, q);
    chk("pop_same", q, 32'h01);
    wb_rd(4'h4, q);
    chk("st_rx3_kept", q, 32'h0000_0314);
    cs_high();
    for (int i = 2; i <= 4; i++) begin
      wb_rd(4'h0, q);
      chk("rx_seq", q, i);
    end
    wb_wr(4'hC, 32'hF);
    cs_low();
    spi_xfer(8'h77, 8, 1'b1, 1'b1, 4'hC, 32'h1, mb, q);
    cs_high();
    wb_rd(4'hC, q);
    chk("irq_setwins", q, IRQ ? 32'hD : 32'h0);
    wb_wr(4'hC, 32'h1);
    wb_rd(4'hC, q);
    chk("irq_w1c_one", q, IRQ ? 32'hC : 32'h0);
    wb_wr(4'h8, 32'h104);
    wb_rd(4'h4, q);
    chk("st_rxflush", q, 32'h0000_0005);
    wb_wr(4'h0, 32'hE7);
    cs_low();
    spi_xfer(8'hF0, 4, 1'b0, 1'b0, 4'd0, 32'd0, mb, q);
    chk("pre_rst_oe", 32'(spi_miso_oe_o), 32'd1);
    #2 rst_i = 1'b1;
    spi_cs_ni = 1'b1;
    spi_sck_i = 1'b0;
    #1 chk("arst_pins", {28'd0, wb_ack_o, spi_miso_o, spi_miso_oe_o, irq_o}, 32'd0);
    chk("arst_dat", wb_dat_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    wb_rd(4'h4, q);
    chk("arst_status", q, 32'h0000_0005);
    wb_rd(4'h8, q);
    chk("arst_ctrl", q, 32'h0);
    wb_wr(4'h0, 32'h3C);
    cs_low();
    spi_byte(8'hA1, mb);
    chk("post_rst_miso", 32'(mb), 32'h3C);
    cs_high();
    wb_rd(4'h0, q);
    chk("post_rst_rx", q, 32'hA1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
